mips_divider: RTL

//  Iterative radix-2 restoring divider for the MIPS div/divu instructions.
//  It is the inverse of the ALU's single-cycle multiply: it produces the quotient
//  and remainder over multiple cycles, which the datapath writes to LO/HI.
//  The datapath raises start for one cycle and stalls the PC while busy is high.
//  It captures the quotient and remainder when done pulses.

---
 rtl/mips_divider.sv | 106 ++++++++++
 1 files changed

// File: rtl/mips_divider.sv
// Iterative radix-2 restoring divider for MIPS div/divu; quotient -> LO, remainder -> HI.
// Fixed latency WIDTH+1 edges after the accepting edge; start is ignored while busy.
module mips_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] dvd_raw;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // The shifted partial remainder needs one extra bit; its MSB after the
  // subtraction is the borrow that decides the quotient bit.
  always_comb begin
    rem_sh = {rem, q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvsr};
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      q           <= '0;
      rem         <= '0;
      dvsr        <= '0;
      dvd_raw     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            neg_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r   <= is_signed & dividend[WIDTH-1];
            q       <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvsr    <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            dvd_raw <= dividend;
            dz      <= (divisor == '0);
            rem     <= '0;
            cnt     <= CW'(WIDTH - 1);
            state   <= S_DIV;
          end
        end
        S_DIV: begin
          if (trial[WIDTH]) begin
            rem <= rem_sh[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b0};
          end else begin
            rem <= trial[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b1};
          end
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - CW'(1);
        end
        S_FIX: begin
          // min/-1 needs no special case: |min| as unsigned divides to min.
          if (dz) begin
            quotient    <= '1;
            remainder   <= dvd_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= neg_q ? -q : q;
            remainder   <= neg_r ? -rem : rem;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
